conv_lut_writer: RTL and testbench

Programmable 16-entry by 2-bit partial-sum lookup table for the bit-serial convolution kernel. A host loads the table serially over a valid/ready stream. The datapath reads it through a registered lookup port that uses the same bit_1..bit_4 to dout_bit1/dout_bit2 encoding as the fixed conv LUT slices. The block lets per-kernel LUT contents be loaded at run time instead of being hard-coded.

---
 rtl/conv_lut_pkg.sv | 24 ++
 rtl/conv_lut_regfile.sv | 41 ++++
 rtl/conv_lut_writer.sv | 115 +++++++++++
 tb/tb_conv_lut_writer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_lut_pkg.sv
// Shared definitions for the programmable conv partial-sum LUT: table geometry,
// loader FSM states and the lookup address packing order.
package conv_lut_pkg;

    localparam int LUT_ADDR_W = 4;
    localparam int LUT_DATA_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } lut_state_e;

    // Same packing as the fixed conv LUT slices: bit_4 is the MSB.
    function automatic logic [LUT_ADDR_W-1:0] pack_addr(
        input logic b4,
        input logic b3,
        input logic b2,
        input logic b1
    );
        return {b4, b3, b2, b1};
    endfunction

endpackage

// File: rtl/conv_lut_regfile.sv
// 2^ADDR_W x DATA_W flop array with one write port and one registered read port.
// A read with rclr_i set loads zero instead of the addressed entry.
module conv_lut_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rclr_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_lut_writer.sv
// Run-time loadable 16x2 partial-sum LUT: serial valid/ready loader FSM plus a
// one-cycle registered lookup port using the conv slice bit_N/dout_bitN encoding.
module conv_lut_writer
    import conv_lut_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_done,
    output logic              table_valid,
    input  logic              lk_valid,
    input  logic              bit_1,
    input  logic              bit_2,
    input  logic              bit_3,
    input  logic              bit_4,
    output logic              dout_bit1,
    output logic              dout_bit2,
    output logic              dout_valid,
    output logic              lk_err
);

    // One spare MSB lets the pointer reach 16 after the final write without wrapping.
    localparam logic [ADDR_W:0] WP_LAST = {1'b0, {ADDR_W{1'b1}}};

    lut_state_e        state_q, state_d;
    logic [ADDR_W:0]   wp_q, wp_d;
    logic              tv_q, tv_d;
    logic              done_q, done_d;
    logic              dvld_q;
    logic              err_q, err_d;
    logic              we;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        tv_d    = tv_q;
        done_d  = 1'b0;
        we      = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    wp_d    = '0;
                    tv_d    = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a handshake in the same cycle.
                if (cfg_start) begin
                    wp_d = '0;
                end else if (cfg_valid) begin
                    we   = 1'b1;
                    wp_d = wp_q + (ADDR_W+1)'(1);
                    if (wp_q == WP_LAST) begin
                        state_d = READY;
                        done_d  = 1'b1;
                        tv_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_d = lk_valid ? ~tv_q : err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wp_q    <= '0;
            tv_q    <= 1'b0;
            done_q  <= 1'b0;
            dvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            tv_q    <= tv_d;
            done_q  <= done_d;
            dvld_q  <= lk_valid;
            err_q   <= err_d;
        end
    end

    conv_lut_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (wp_q[ADDR_W-1:0]),
        .wdata_i (cfg_data),
        .re_i    (lk_valid),
        .rclr_i  (~tv_q),
        .raddr_i (pack_addr(bit_4, bit_3, bit_2, bit_1)),
        .rdata_o (rdata)
    );

    assign cfg_ready   = (state_q == LOAD);
    assign cfg_done    = done_q;
    assign table_valid = tv_q;
    assign dout_valid  = dvld_q;
    assign lk_err      = err_q;
    assign dout_bit1   = rdata[0];
    assign dout_bit2   = rdata[1];

endmodule

// File: tb/tb_conv_lut_writer.sv
// Bench for conv_lut_writer: scenario tasks drive loads and lookups, a queue
// scoreboard checks every dout_valid result and the hold behaviour in between.
module tb_conv_lut_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_data = 2'b00;
    logic       cfg_done;
    logic       table_valid;
    logic       lk_valid = 1'b0;
    logic       bit_1 = 1'b0, bit_2 = 1'b0, bit_3 = 1'b0, bit_4 = 1'b0;
    logic       dout_bit1, dout_bit2, dout_valid, lk_err;

    conv_lut_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_done    (cfg_done),
        .table_valid (table_valid),
        .lk_valid    (lk_valid),
        .bit_1       (bit_1),
        .bit_2       (bit_2),
        .bit_3       (bit_3),
        .bit_4       (bit_4),
        .dout_bit1   (dout_bit1),
        .dout_bit2   (dout_bit2),
        .dout_valid  (dout_valid),
        .lk_err      (lk_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic       mon_en = 1'b0;
    logic [2:0] last_out = 3'b000;
    logic [2:0] exp_q [$];

    // Expected-behaviour model state: {err, dout_bit2, dout_bit1} per lookup.
    logic [1:0] exp_tbl [16];
    logic       exp_load = 1'b0;
    logic       exp_tv = 1'b0;
    logic       exp_done = 1'b0;
    int         exp_wp = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (cfg_done) done_cnt++;
            checks++;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: dout_valid=1 with no pending lookup");
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if ({lk_err, dout_bit2, dout_bit1} !== e) begin
                        errors++;
                        $display("FAIL sb_result: {err,d2,d1} got %b required %b", {lk_err, dout_bit2, dout_bit1}, e);
                    end
                end
                last_out = {lk_err, dout_bit2, dout_bit1};
            end else if ({lk_err, dout_bit2, dout_bit1} !== last_out) begin
                errors++;
                $display("FAIL sb_hold: {err,d2,d1} got %b required held %b", {lk_err, dout_bit2, dout_bit1}, last_out);
            end
        end
    end

    task automatic apply_reset();
        mon_en    = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        lk_valid  = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_load = 1'b0;
        exp_tv   = 1'b0;
        exp_done = 1'b0;
        exp_wp   = 0;
        for (int i = 0; i < 16; i++) exp_tbl[i] = 2'b00;
        exp_q.delete();
        last_out = 3'b000;
        mon_en   = 1'b1;
    endtask

    // One clock of stimulus, then control outputs are compared with the model.
    task automatic drive_cycle(input logic st, input logic vl, input logic [1:0] dt,
                               input logic lk, input logic [3:0] addr);
        cfg_start = st;
        cfg_valid = vl;
        cfg_data  = dt;
        lk_valid  = lk;
        {bit_4, bit_3, bit_2, bit_1} = addr;
        if (lk) exp_q.push_back(exp_tv ? {1'b0, exp_tbl[addr]} : 3'b100);
        @(posedge clk);
        exp_done = 1'b0;
        if (exp_load) begin
            if (st) begin
                exp_wp = 0;
            end else if (vl) begin
                exp_tbl[exp_wp] = dt;
                if (exp_wp == 15) begin
                    exp_load = 1'b0;
                    exp_tv   = 1'b1;
                    exp_done = 1'b1;
                end
                exp_wp++;
            end
        end else if (st) begin
            exp_load = 1'b1;
            exp_wp   = 0;
            exp_tv   = 1'b0;
        end
        @(negedge clk);
        checks += 3;
        if (cfg_ready !== exp_load) begin
            errors++;
            $display("FAIL cfg_ready: got %b required %b", cfg_ready, exp_load);
        end
        if (table_valid !== exp_tv) begin
            errors++;
            $display("FAIL table_valid: got %b required %b", table_valid, exp_tv);
        end
        if (cfg_done !== exp_done) begin
            errors++;
            $display("FAIL cfg_done: got %b required %b", cfg_done, exp_done);
        end
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b0, 4'h0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cfg_ready, cfg_done, table_valid, dout_valid, lk_err, dout_bit2, dout_bit1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {cfg_ready, cfg_done, table_valid, dout_valid, lk_err, dout_bit2, dout_bit1});
        end
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'h5);
        checks++;
        if ({dout_valid, lk_err, dout_bit2, dout_bit1} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_lookup: {vld,err,d2,d1} got %b required 1100", {dout_valid, lk_err, dout_bit2, dout_bit1});
        end
        idle();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_lookup_pulse: dout_valid got %b required 0", dout_valid);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) drive_cycle(1'b0, 1'b1, 2'(i % 4), 1'b0, 4'h0);
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'hE);
        checks++;
        if ({lk_err, dout_bit2, dout_bit1} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_addr_E: {err,d2,d1} got %b required 010", {lk_err, dout_bit2, dout_bit1});
        end
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'h7);
        checks++;
        if ({lk_err, dout_bit2, dout_bit1} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_addr_7: {err,d2,d1} got %b required 011", {lk_err, dout_bit2, dout_bit1});
        end
        idle();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_toggle_load();
        int n;
        n = 0;
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 1'(i % 2), 2'($urandom_range(0, 3)), 1'b0, 4'h0);
            n++;
            if (cfg_done === 1'b1) break;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL toggle_cycles: cycles to cfg_done got %0d required 32", n);
        end
        for (int a = 0; a < 16; a++) drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'(a));
        idle();
    endtask

    task automatic test_restart();
        int d0;
        d0 = done_cnt;
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, 2'($urandom_range(0, 2)), 1'b0, 4'h0);
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) drive_cycle(1'b0, 1'b1, 2'b11, 1'b0, 4'h0);
        for (int a = 0; a < 16; a++) begin
            drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'(a));
            checks++;
            if ({lk_err, dout_bit2, dout_bit1} !== 3'b011) begin
                errors++;
                $display("FAIL restart_read addr %0d: {err,d2,d1} got %b required 011", a, {lk_err, dout_bit2, dout_bit1});
            end
        end
        idle();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL restart_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_midload();
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 1'b1, 2'b10, 1'b0, 4'h0);
        apply_reset();
        checks++;
        if ({cfg_ready, table_valid} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_ctrl: {ready,tv} got %b required 00", {cfg_ready, table_valid});
        end
        drive_cycle(1'b0, 1'b1, 2'b11, 1'b0, 4'h0);
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'h3);
        checks++;
        if ({dout_valid, lk_err, dout_bit2, dout_bit1} !== 4'b1100) begin
            errors++;
            $display("FAIL midreset_lookup: {vld,err,d2,d1} got %b required 1100", {dout_valid, lk_err, dout_bit2, dout_bit1});
        end
        idle();
    endtask

    task automatic test_done_cycle_lookup();
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 15; i++) drive_cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 4'h0);
        drive_cycle(1'b0, 1'b1, 2'b01, 1'b1, 4'hF);
        checks++;
        if ({dout_valid, lk_err, dout_bit2, dout_bit1} !== 4'b1100) begin
            errors++;
            $display("FAIL done_cycle_lookup: {vld,err,d2,d1} got %b required 1100", {dout_valid, lk_err, dout_bit2, dout_bit1});
        end
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b1, 4'hF);
        checks++;
        if ({dout_valid, lk_err, dout_bit2, dout_bit1} !== 4'b1001) begin
            errors++;
            $display("FAIL after_done_lookup: {vld,err,d2,d1} got %b required 1001", {dout_valid, lk_err, dout_bit2, dout_bit1});
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle_load();
        test_restart();
        test_reset_midload();
        test_done_cycle_lookup();
        idle();
        idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending lookups got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
